// File: rtl/axil_prefetch_pkg.sv
// Shared types for the AXI4-Lite prefetch master: FSM states, run modes and
// response codes.
package axil_prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_WR_RD  = 2'b00,
        MODE_WR     = 2'b01,
        MODE_RD_CMP = 2'b10,
        MODE_RD     = 2'b11
    } mode_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    localparam int BEAT_W = 8;
    localparam int ERR_W  = 9;

    // SLVERR and DECERR both count as a failed beat.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return !((resp == RESP_OKAY) || (resp == RESP_EXOKAY));
    endfunction

endpackage

// File: rtl/axil_prefetch_pattern.sv
// Maps a beat index to the target byte address and the expected data word.
module axil_prefetch_pattern
    import axil_prefetch_pkg::*;
#(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32,
    parameter logic [31:0] C_M_START_DATA_VALUE       = 32'hAA00_0000
)(
    input  logic [BEAT_W-1:0]             i_beat,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_addr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_data
);

    localparam int BYTE_SHIFT = (C_M_AXI_DATA_WIDTH == 64) ? 3 : 2;

    assign o_addr = C_M_AXI_ADDR_WIDTH'(C_M_TARGET_SLAVE_BASE_ADDR)
                  + (C_M_AXI_ADDR_WIDTH'(i_beat) << BYTE_SHIFT);
    assign o_data = C_M_AXI_DATA_WIDTH'(C_M_START_DATA_VALUE)
                  + C_M_AXI_DATA_WIDTH'(i_beat);

endmodule

// File: rtl/axil_prefetch_master.sv
// AXI4-Lite master that writes and/or reads back a counting pattern, one
// transaction outstanding at a time, and tallies failing beats.
//
//   state    | meaning
//   ST_IDLE  | after reset, waiting for a start edge
//   ST_WRITE | issuing AW+W beats, one B outstanding
//   ST_READ  | issuing AR beats, one R outstanding, checking data/resp
//   ST_DONE  | run finished, TXN_DONE high, waiting for the next start
module axil_prefetch_master
    import axil_prefetch_pkg::*;
#(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32,
    parameter int          C_M_TRANSACTIONS_NUM       = 4,
    parameter logic [31:0] C_M_START_DATA_VALUE       = 32'hAA00_0000
)(
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              INIT_AXI_TXN,
    input  logic [1:0]                        MODE,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [ERR_W-1:0]                  ERR_COUNT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     FIRST_ERR_ADDR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_M_TRANSACTIONS_NUM - 1);

    state_e                          r_state;
    mode_e                           r_mode;
    logic                            r_init_q;
    logic [BEAT_W-1:0]               r_beat;
    logic                            r_awvalid;
    logic                            r_wvalid;
    logic                            r_bready;
    logic                            r_arvalid;
    logic                            r_rready;
    logic                            r_txn_done;
    logic                            r_error;
    logic [ERR_W-1:0]                r_err_count;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_first_err_addr;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   w_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   w_data;
    logic                            w_start;
    logic                            w_last;
    logic                            w_cmp;
    logic                            w_b_hs;
    logic                            w_r_hs;
    logic                            w_fail;
    logic                            w_aw_clear;
    logic                            w_w_clear;

    axil_prefetch_pattern #(
        .C_M_TARGET_SLAVE_BASE_ADDR (C_M_TARGET_SLAVE_BASE_ADDR),
        .C_M_AXI_ADDR_WIDTH         (C_M_AXI_ADDR_WIDTH),
        .C_M_AXI_DATA_WIDTH         (C_M_AXI_DATA_WIDTH),
        .C_M_START_DATA_VALUE       (C_M_START_DATA_VALUE)
    ) u_pattern (
        .i_beat (r_beat),
        .o_addr (w_addr),
        .o_data (w_data)
    );

    // r_init_q resets high so a level already present at reset release is not an edge.
    assign w_start    = INIT_AXI_TXN && !r_init_q && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last     = (r_beat == LAST_BEAT);
    assign w_cmp      = (r_mode == MODE_WR_RD) || (r_mode == MODE_RD_CMP);
    assign w_b_hs     = r_bready && M_AXI_BVALID;
    assign w_r_hs     = r_rready && M_AXI_RVALID;
    assign w_aw_clear = !r_awvalid || M_AXI_AWREADY;
    assign w_w_clear  = !r_wvalid || M_AXI_WREADY;
    assign w_fail     = (w_b_hs && resp_is_err(M_AXI_BRESP))
                     || (w_r_hs && (resp_is_err(M_AXI_RRESP) || (w_cmp && (M_AXI_RDATA != w_data))));

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state          <= ST_IDLE;
            r_mode           <= MODE_WR_RD;
            r_init_q         <= 1'b1;
            r_beat           <= '0;
            r_awvalid        <= 1'b0;
            r_wvalid         <= 1'b0;
            r_bready         <= 1'b0;
            r_arvalid        <= 1'b0;
            r_rready         <= 1'b0;
            r_txn_done       <= 1'b0;
            r_error          <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else begin
            r_init_q <= INIT_AXI_TXN;
            if (w_fail) begin
                r_error <= 1'b1;
                if (r_err_count != '1) r_err_count <= r_err_count + ERR_W'(1);
                if (!r_error) r_first_err_addr <= w_addr;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_mode           <= mode_e'(MODE);
                        r_beat           <= '0;
                        r_txn_done       <= 1'b0;
                        r_error          <= 1'b0;
                        r_err_count      <= '0;
                        r_first_err_addr <= '0;
                        if (!MODE[1]) begin
                            r_state   <= ST_WRITE;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= ST_READ;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
                    if ((r_awvalid || r_wvalid) && w_aw_clear && w_w_clear) r_bready <= 1'b1;
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        if (w_last) begin
                            r_beat <= '0;
                            if (r_mode == MODE_WR_RD) begin
                                r_state   <= ST_READ;
                                r_arvalid <= 1'b1;
                            end else begin
                                r_state    <= ST_DONE;
                                r_txn_done <= 1'b1;
                            end
                        end else begin
                            r_beat    <= r_beat + BEAT_W'(1);
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (r_arvalid && M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                    if (w_r_hs) begin
                        r_rready <= 1'b0;
                        if (w_last) begin
                            r_beat     <= '0;
                            r_state    <= ST_DONE;
                            r_txn_done <= 1'b1;
                        end else begin
                            r_beat    <= r_beat + BEAT_W'(1);
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign TXN_DONE       = r_txn_done;
    assign ERROR          = r_error;
    assign ERR_COUNT      = r_err_count;
    assign FIRST_ERR_ADDR = r_first_err_addr;
    assign M_AXI_AWADDR   = w_addr;
    assign M_AXI_AWPROT   = 3'b000;
    assign M_AXI_AWVALID  = r_awvalid;
    assign M_AXI_WDATA    = w_data;
    assign M_AXI_WSTRB    = '1;
    assign M_AXI_WVALID   = r_wvalid;
    assign M_AXI_BREADY   = r_bready;
    assign M_AXI_ARADDR   = w_addr;
    assign M_AXI_ARPROT   = 3'b000;
    assign M_AXI_ARVALID  = r_arvalid;
    assign M_AXI_RREADY   = r_rready;

endmodule

// File: tb/tb_axil_prefetch_master.sv
// Randomized bench for axil_prefetch_master: a bench-side slave with random
// ready/response latencies, and a run-level model of addresses, data and errors.
module tb_axil_prefetch_master;

    localparam int          N     = 4;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam logic [31:0] START = 32'hAA00_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic init = 1'b0;
    logic [1:0] mode = 2'b00;

    logic        txn_done, error;
    logic [8:0]  err_count;
    logic [31:0] first_err_addr;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic [31:0] rdata = 0;

    always #5 clk = ~clk;

    axil_prefetch_master dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .INIT_AXI_TXN(init), .MODE(mode),
        .TXN_DONE(txn_done), .ERROR(error), .ERR_COUNT(err_count), .FIRST_ERR_ADDR(first_err_addr),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int total = 0, bad = 0;

    logic [1:0]  bresp_t [N];
    logic [1:0]  rresp_t [N];
    logic [31:0] corrupt_t [N];

    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int aw_lat, w_lat, b_lat, ar_lat, r_lat;
    int lat_max = 0, aw_fixed = -1;
    logic p_awvalid, p_wvalid, p_arvalid, p_aw_hs, p_w_hs, p_ar_hs;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [31:0] last_awaddr, last_wdata, first_awaddr;
    bit exp_writes, exp_reads, exp_cmp;
    logic [8:0]  exp_err;
    logic [31:0] exp_first;

    function automatic logic [31:0] exp_addr(int i);
        return BASE + 32'(i) * 32'd4;
    endfunction

    function automatic logic [31:0] exp_data(int i);
        return START + 32'(i);
    endfunction

    function automatic int pick_lat();
        return int'($urandom_range(0, lat_max));
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, expv, $time);
        end
    endtask

    task automatic reset_slave();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_lat = (aw_fixed >= 0) ? aw_fixed : pick_lat();
        w_lat = pick_lat(); b_lat = pick_lat(); ar_lat = pick_lat(); r_lat = pick_lat();
        p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
    endtask

    // One cycle: check DUT outputs, drive the slave, then record handshakes
    // that will occur at the coming rising edge.
    task automatic tick();
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pend, r_pend;
        @(negedge clk);
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            return;
        end
        if (p_awvalid && !p_aw_hs) begin chk("awvalid_hold", awvalid, 1); chk("awaddr_hold", awaddr, p_awaddr); end
        if (p_wvalid && !p_w_hs)   begin chk("wvalid_hold", wvalid, 1);   chk("wdata_hold", wdata, p_wdata); end
        if (p_arvalid && !p_ar_hs) begin chk("arvalid_hold", arvalid, 1); chk("araddr_hold", araddr, p_araddr); end
        if (awvalid && !p_awvalid) begin
            chk("aw_w_together", {wvalid, p_wvalid}, 2'b10);
            chk("w_one_outstanding", aw_cnt - b_cnt, 0);
        end
        if (wvalid && !p_wvalid) chk("w_aw_together", {awvalid, p_awvalid}, 2'b10);
        if (arvalid && !p_arvalid) begin
            chk("r_one_outstanding", ar_cnt - r_cnt, 0);
            chk("ar_after_writes", b_cnt, exp_writes ? N : 0);
        end
        if (awvalid || wvalid) chk("wstrb_awprot", {wstrb, awprot}, {4'hF, 3'b000});
        if (arvalid) chk("arprot", arprot, 0);
        if (bready) chk("bready_pending", (aw_cnt > b_cnt) && (w_cnt > b_cnt), 1);
        if (rready) chk("rready_pending", ar_cnt > r_cnt, 1);

        awready = awvalid && (aw_wait >= aw_lat);
        if (awvalid && !awready) aw_wait++;
        wready = wvalid && (w_wait >= w_lat);
        if (wvalid && !wready) w_wait++;
        arready = arvalid && (ar_wait >= ar_lat);
        if (arvalid && !arready) ar_wait++;
        b_pend = (aw_cnt > b_cnt) && (w_cnt > b_cnt) && (b_cnt < N);
        bvalid = b_pend && (b_wait >= b_lat);
        bresp  = b_pend ? bresp_t[b_cnt] : 2'b00;
        if (b_pend && !bvalid) b_wait++;
        r_pend = (ar_cnt > r_cnt) && (r_cnt < N);
        rvalid = r_pend && (r_wait >= r_lat);
        rresp  = r_pend ? rresp_t[r_cnt] : 2'b00;
        rdata  = r_pend ? (exp_data(r_cnt) ^ corrupt_t[r_cnt]) : 32'h0;
        if (r_pend && !rvalid) r_wait++;

        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        ar_hs = arvalid && arready;
        b_hs  = bvalid && bready;
        r_hs  = rvalid && rready;
        if (aw_hs) begin
            chk("aw_allowed", exp_writes && (aw_cnt < N), 1);
            chk("awaddr", awaddr, exp_addr(aw_cnt));
            if (aw_cnt == 0) first_awaddr = awaddr;
            last_awaddr = awaddr;
            aw_cnt++; aw_wait = 0; aw_lat = (aw_fixed >= 0) ? aw_fixed : pick_lat();
        end
        if (w_hs) begin
            chk("w_allowed", exp_writes && (w_cnt < N), 1);
            chk("wdata", wdata, exp_data(w_cnt));
            last_wdata = wdata;
            w_cnt++; w_wait = 0; w_lat = pick_lat();
        end
        if (ar_hs) begin
            chk("ar_allowed", exp_reads && (ar_cnt < N), 1);
            chk("araddr", araddr, exp_addr(ar_cnt));
            ar_cnt++; ar_wait = 0; ar_lat = pick_lat();
        end
        if (b_hs) begin b_cnt++; b_wait = 0; b_lat = pick_lat(); end
        if (r_hs) begin r_cnt++; r_wait = 0; r_lat = pick_lat(); end
        p_awvalid = awvalid; p_wvalid = wvalid; p_arvalid = arvalid;
        p_aw_hs = aw_hs; p_w_hs = w_hs; p_ar_hs = ar_hs;
        p_awaddr = awaddr; p_wdata = wdata; p_araddr = araddr;
    endtask

    task automatic set_tables(input logic [1:0] bres, input logic [1:0] rres);
        for (int i = 0; i < N; i++) begin
            bresp_t[i] = bres; rresp_t[i] = rres; corrupt_t[i] = 32'h0;
        end
    endtask

    // Run-level expectations: which phases happen and which beats must fail.
    task automatic begin_run(input logic [1:0] m);
        int e;
        exp_writes = (m[1] == 1'b0);
        exp_reads  = (m != 2'b01);
        exp_cmp    = (m == 2'b00) || (m == 2'b10);
        e = 0; exp_first = 32'h0;
        if (exp_writes)
            for (int i = 0; i < N; i++)
                if (bresp_t[i][1]) begin if (e == 0) exp_first = exp_addr(i); e++; end
        if (exp_reads)
            for (int i = 0; i < N; i++)
                if (rresp_t[i][1] || (exp_cmp && corrupt_t[i] != 0)) begin
                    if (e == 0) exp_first = exp_addr(i);
                    e++;
                end
        exp_err = (e > 511) ? 9'd511 : 9'(e);
        reset_slave();
        first_awaddr = 32'hFFFF_FFFF; last_awaddr = 0; last_wdata = 0;
        mode = m;
        init = 1'b1;
        tick();
        chk("start_clears", {txn_done, error, err_count, first_err_addr}, 0);
        init = 1'b0;
    endtask

    task automatic finish_run(input bit poke);
        int k;
        k = 0;
        while (!txn_done && k < 600) begin
            if (poke && k == 2) begin init = 1'b1; mode = ~mode; end
            if (poke && k == 3) init = 1'b0;
            tick();
            k++;
        end
        init = 1'b0;
        chk("done_reached", txn_done, 1);
        chk("aw_count", aw_cnt, exp_writes ? N : 0);
        chk("w_count",  w_cnt,  exp_writes ? N : 0);
        chk("b_count",  b_cnt,  exp_writes ? N : 0);
        chk("ar_count", ar_cnt, exp_reads ? N : 0);
        chk("r_count",  r_cnt,  exp_reads ? N : 0);
        chk("error", error, exp_err != 0);
        chk("err_count", err_count, exp_err);
        chk("first_err_addr", first_err_addr, exp_first);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("quiet_after_done", {awvalid, wvalid, arvalid}, 3'b000);
            chk("done_held", txn_done, 1);
        end
    endtask

    initial begin
        int loops;
        set_tables(2'b00, 2'b00);
        exp_writes = 0; exp_reads = 0; exp_cmp = 0;
        init = 1'b1;
        #2 rst_n = 1'b0;
        reset_slave();
        tick(); tick();
        chk("reset_outputs", {txn_done, error, awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("reset_err_count", err_count, 0);
        chk("reset_first_err", first_err_addr, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_start_after_reset", {awvalid, arvalid}, 2'b00);
        end
        init = 1'b0;
        tick();

        // Clean write + read-compare with an always-ready slave.
        lat_max = 0;
        set_tables(2'b00, 2'b00);
        begin_run(2'b00);
        finish_run(0);
        chk("pin_first_awaddr", first_awaddr, 32'h4000_0000);
        chk("pin_last_awaddr", last_awaddr, 32'h4000_000C);
        chk("pin_last_wdata", last_wdata, 32'hAA00_0003);
        chk("pin_clean_errors", {error, err_count}, 0);

        // Read of beat 2 corrupted.
        set_tables(2'b00, 2'b00);
        corrupt_t[2] = 32'h0000_0100;
        begin_run(2'b00);
        finish_run(0);
        chk("pin_corrupt_addr", first_err_addr, 32'h4000_0008);
        chk("pin_corrupt_count", {error, err_count}, {1'b1, 9'd1});
        chk("pin_corrupt_reads", r_cnt, 4);

        // Write-only with AWREADY three cycles behind WREADY.
        set_tables(2'b00, 2'b00);
        aw_fixed = 3;
        begin_run(2'b01);
        finish_run(0);
        chk("pin_wo_b", b_cnt, 4);
        chk("pin_wo_ar", ar_cnt, 0);

        // Reset pulse while beat 2 is being issued.
        begin_run(2'b01);
        loops = 0;
        while (!(aw_cnt == 2 && awvalid) && loops < 100) begin tick(); loops++; end
        chk("reached_beat2", (aw_cnt == 2) && awvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_valids", {awvalid, wvalid, bready, arvalid, rready, txn_done}, 0);
        chk("reset_mid_errs", {error, err_count, first_err_addr}, 0);
        aw_fixed = -1;
        reset_slave();
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_after_reset", {awvalid, wvalid, arvalid}, 3'b000);
        begin_run(2'b00);
        finish_run(0);
        chk("pin_restart_beat0", first_awaddr, 32'h4000_0000);

        // Read-compare only, with a second start edge and MODE change mid-run.
        lat_max = 2;
        set_tables(2'b00, 2'b01);
        begin_run(2'b10);
        finish_run(1);
        chk("pin_busy_ar", ar_cnt, 4);
        chk("pin_busy_aw", aw_cnt, 0);

        // Read-only with every response SLVERR.
        set_tables(2'b10, 2'b10);
        begin_run(2'b11);
        finish_run(0);
        chk("pin_slverr_count", err_count, 4);
        chk("pin_slverr_error", error, 1);
        chk("pin_slverr_addr", first_err_addr, 32'h4000_0000);

        for (int r = 0; r < 30; r++) begin
            lat_max = int'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                bresp_t[i] = ($urandom_range(0, 3) == 0) ? {1'b1, 1'($urandom_range(0, 1))}
                                                         : {1'b0, 1'($urandom_range(0, 1))};
                rresp_t[i] = ($urandom_range(0, 3) == 0) ? {1'b1, 1'($urandom_range(0, 1))}
                                                         : {1'b0, 1'($urandom_range(0, 1))};
                corrupt_t[i] = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            end
            begin_run(2'($urandom_range(0, 3)));
            finish_run(1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
